// File: rtl/branch_pkg.sv
// Shared decode constants for the D-stage branch unit: branch class codes,
// MIPS opcodes and REGIMM rt selectors.
package branch_pkg;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BGTZ = 3'b001,
    CMP_BLEZ = 3'b010,
    CMP_BNE  = 3'b011,
    CMP_BGEZ = 3'b100,
    CMP_BLTZ = 3'b101,
    CMP_NONE = 3'b111
  } cmp_op_e;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/branch_pht.sv
// Pattern history table of saturating counters: combinational F-stage lookup,
// clocked D-stage training with read-before-write on a shared index.
module branch_pht #(
  parameter  int PHT_DEPTH = 16,
  parameter  int CNT_W     = 2,
  parameter  int CNT_RST   = 1,
  localparam int IDX_W     = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_RST);

  logic [CNT_W-1:0] cnt_q [PHT_DEPTH];

  // NOTE: the table is a handful of flops, not a RAM macro, so every entry is
  // reset in place; predictions after reset must be deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd_en) begin
      // NOTE: non-blocking update keeps the lookup below on the old value
      // this cycle, which is exactly the read-before-write behaviour wanted.
      if (upd_taken && cnt_q[upd_idx] != CNT_MAX)
        cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_W'(1);
      else if (!upd_taken && cnt_q[upd_idx] != '0)
        cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_W'(1);
    end
  end

  assign rd_taken = cnt_q[rd_idx][CNT_W-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// D-stage branch decode/compare, PHT prediction and training, misprediction flag.
// Define BRANCH_RESOLVE_STATS_EN to build the resolved/mispredicted branch counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PHT_DEPTH = 16,
  parameter int CNT_W     = 2,
  parameter int CNT_RST   = 1,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_f,
  output logic              pred_taken_f,
  input  logic              en_d,
  input  logic [31:0]       instr_d,
  input  logic [31:0]       pc_d,
  input  logic              pred_d,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              opnd_rdy,
  output logic [2:0]        cmp_op,
  output logic              is_branch,
  output logic              is_link,
  output logic              taken_d,
  output logic              mispredict_d,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mp_count
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [5:0] opcode;
  logic [4:0] rt_sel;
  cmp_op_e    op;
  logic       link;
  logic       cond;
  logic       resolve;

  assign opcode = instr_d[31:26];
  assign rt_sel = instr_d[20:16];

  // NOTE: defaults first so every path assigns op/link and no latch is inferred.
  always_comb begin
    op   = CMP_NONE;
    link = 1'b0;
    unique case (opcode)
      OP_BEQ:  op = CMP_BEQ;
      OP_BNE:  op = CMP_BNE;
      OP_BLEZ: op = CMP_BLEZ;
      OP_BGTZ: op = CMP_BGTZ;
      OP_REGIMM: begin
        unique case (rt_sel)
          RT_BLTZ:   op = CMP_BLTZ;
          RT_BGEZ:   op = CMP_BGEZ;
          RT_BLTZAL: begin op = CMP_BLTZ; link = 1'b1; end
          RT_BGEZAL: begin op = CMP_BGEZ; link = 1'b1; end
          default:   op = CMP_NONE;
        endcase
      end
      default: op = CMP_NONE;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    unique case (op)
      CMP_BEQ:  cond = (rs_val == rt_val);
      CMP_BNE:  cond = (rs_val != rt_val);
      CMP_BGTZ: cond = ($signed(rs_val) >  0);
      CMP_BLEZ: cond = ($signed(rs_val) <= 0);
      CMP_BGEZ: cond = ($signed(rs_val) >= 0);
      CMP_BLTZ: cond = ($signed(rs_val) <  0);
      default:  cond = 1'b0;
    endcase
  end

  assign cmp_op       = op;
  assign is_branch    = (op != CMP_NONE);
  assign is_link      = link;
  assign resolve      = is_branch & en_d & opnd_rdy;
  assign taken_d      = resolve & cond;
  assign mispredict_d = resolve & (cond != pred_d);

  branch_pht #(
    .PHT_DEPTH (PHT_DEPTH),
    .CNT_W     (CNT_W),
    .CNT_RST   (CNT_RST)
  ) u_pht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_f[IDX_W+1:2]),
    .rd_taken  (pred_taken_f),
    .upd_en    (resolve),
    .upd_idx   (pc_d[IDX_W+1:2]),
    .upd_taken (cond)
  );

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [STAT_W-1:0] br_q;
  logic [STAT_W-1:0] mp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (resolve) begin
      if (br_q != '1) br_q <= br_q + STAT_W'(1);
      if (mispredict_d && mp_q != '1) mp_q <= mp_q + STAT_W'(1);
    end
  end

  assign br_count = br_q;
  assign mp_count = mp_q;
`else
  assign br_count = '0;
  assign mp_count = '0;
`endif

  // Instruction and PC bits outside the decode fields and PHT index.
  logic unused_bits;
  assign unused_bits = ^{instr_d[25:21], instr_d[15:0],
                         pc_f[31:IDX_W+2], pc_f[1:0],
                         pc_d[31:IDX_W+2], pc_d[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default parameters).
module tb_branch_resolve_unit;

  localparam logic [31:0] I_BEQ    = 32'h1022_0004;
  localparam logic [31:0] I_BNE    = 32'h1422_0004;
  localparam logic [31:0] I_BLEZ   = 32'h1820_0004;
  localparam logic [31:0] I_BGTZ   = 32'h1C20_0004;
  localparam logic [31:0] I_BGEZAL = 32'h0431_0004;
  localparam logic [31:0] I_BLTZAL = 32'h0430_0004;
  localparam logic [31:0] I_BLTZ   = 32'h0420_0004;
  localparam logic [31:0] I_RIMBAD = 32'h0422_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic        en_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        pred_d;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        opnd_rdy;
  logic [2:0]  cmp_op;
  logic        is_branch;
  logic        is_link;
  logic        taken_d;
  logic        mispredict_d;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pc_f         (pc_f),
    .pred_taken_f (pred_taken_f),
    .en_d         (en_d),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pred_d       (pred_d),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .opnd_rdy     (opnd_rdy),
    .cmp_op       (cmp_op),
    .is_branch    (is_branch),
    .is_link      (is_link),
    .taken_d      (taken_d),
    .mispredict_d (mispredict_d),
    .br_count     (br_count),
    .mp_count     (mp_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic check_stats(input string tag, input int br, input int mp);
`ifdef BRANCH_RESOLVE_STATS_EN
    check({tag, "_br"}, br_count, br);
    check({tag, "_mp"}, mp_count, mp);
`else
    check({tag, "_br"}, br_count, 32'd0 & br);
    check({tag, "_mp"}, mp_count, 32'd0 & mp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input logic pd, input logic en, input logic rdy,
                       input logic [31:0] pcd, input logic [31:0] pcf);
    instr_d  = ins;
    rs_val   = rs;
    rt_val   = rt;
    pred_d   = pd;
    en_d     = en;
    opnd_rdy = rdy;
    pc_d     = pcd;
    pc_f     = pcf;
    #1;
  endtask

  task automatic peek(input logic [31:0] pcf);
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, pcf);
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3000);
    tick();
    tick();
    reset = 1'b0;

    // Reset state and a non-branch word
    peek(32'h3000);
    check("rst_pred", pred_taken_f, 1'b0);
    check("nop_cmp", cmp_op, 3'b111);
    check("nop_isbr", is_branch, 1'b0);
    check("nop_taken", taken_d, 1'b0);
    check("nop_mp", mispredict_d, 1'b0);
    check_stats("rst", 0, 0);

    // beq equal, predicted not-taken; same-index read sees old counter
    drive(I_BEQ, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 32'h3004, 32'h3004);
    check("beq_cmp", cmp_op, 3'b000);
    check("beq_isbr", is_branch, 1'b1);
    check("beq_taken", taken_d, 1'b1);
    check("beq_mp", mispredict_d, 1'b1);
    check("beq_rbw", pred_taken_f, 1'b0);
    tick();
    peek(32'h3004);
    check("beq_trained", pred_taken_f, 1'b1);

    // bne not equal, predicted taken
    drive(I_BNE, 32'd5, 32'd6, 1'b1, 1'b1, 1'b1, 32'h3008, 32'h3000);
    check("bne_cmp", cmp_op, 3'b011);
    check("bne_taken", taken_d, 1'b1);
    check("bne_mp", mispredict_d, 1'b0);
    tick();

    // bgtz with most-negative rs: signed compare says not taken
    drive(I_BGTZ, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300C, 32'h3000);
    check("bgtz_cmp", cmp_op, 3'b001);
    check("bgtz_taken", taken_d, 1'b0);
    check("bgtz_mp", mispredict_d, 1'b0);
    tick();
    peek(32'h3000);
    check_stats("three", 3, 1);

    drive(I_BLEZ, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3010, 32'h3000);
    check("blez_cmp", cmp_op, 3'b010);
    check("blez_taken", taken_d, 1'b1);
    tick();

    drive(I_BGEZAL, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3014, 32'h3000);
    check("bgezal_cmp", cmp_op, 3'b100);
    check("bgezal_link", is_link, 1'b1);
    check("bgezal_taken", taken_d, 1'b1);
    tick();

    drive(I_BLTZAL, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3018, 32'h3000);
    check("bltzal_cmp", cmp_op, 3'b101);
    check("bltzal_link", is_link, 1'b1);
    check("bltzal_taken", taken_d, 1'b0);
    tick();

    // bltz decoded while stalled: no link, nothing resolves
    drive(I_BLTZ, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3018, 32'h3000);
    check("bltz_cmp", cmp_op, 3'b101);
    check("bltz_link", is_link, 1'b0);
    check("bltz_stall_taken", taken_d, 1'b0);
    tick();

    // REGIMM with an unknown rt is not a branch and must not touch PHT slot 1
    drive(I_RIMBAD, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3004, 32'h3004);
    check("rimbad_cmp", cmp_op, 3'b111);
    check("rimbad_isbr", is_branch, 1'b0);
    check("rimbad_mp", mispredict_d, 1'b0);
    tick();
    peek(32'h3004);
    check("rimbad_pht", pred_taken_f, 1'b1);
    check_stats("six", 6, 1);

    // Five taken resolves at slot 1 (counter 10): saturates at 11, no wrap
    for (int i = 0; i < 5; i++) begin
      drive(I_BEQ, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1, 32'h3004, 32'h3004);
      tick();
      peek(32'h3004);
      check($sformatf("sat_hi_%0d", i), pred_taken_f, 1'b1);
    end
    // Not-taken: 11 -> 10 still predicts taken; again: 10 -> 01
    drive(I_BEQ, 32'd5, 32'd6, 1'b1, 1'b1, 1'b1, 32'h3004, 32'h3004);
    check("nt1_mp", mispredict_d, 1'b1);
    tick();
    peek(32'h3004);
    check("nt1_pred", pred_taken_f, 1'b1);
    drive(I_BEQ, 32'd5, 32'd6, 1'b1, 1'b1, 1'b1, 32'h3004, 32'h3004);
    tick();
    peek(32'h3004);
    check("nt2_pred", pred_taken_f, 1'b0);
    check_stats("sat", 13, 3);

    // Slot 3 sits at 00: another not-taken holds it at 00, then two takens
    drive(I_BGTZ, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300C, 32'h300C);
    tick();
    drive(I_BEQ, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 32'h300C, 32'h300C);
    tick();
    peek(32'h300C);
    check("sat_lo_01", pred_taken_f, 1'b0);
    drive(I_BEQ, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 32'h300C, 32'h300C);
    tick();
    peek(32'h300C);
    check("sat_lo_10", pred_taken_f, 1'b1);

    // Operands not ready, then stage stalled: no resolve, no training
    drive(I_BEQ, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0, 32'h301C, 32'h301C);
    check("rdy0_taken", taken_d, 1'b0);
    check("rdy0_mp", mispredict_d, 1'b0);
    tick();
    drive(I_BEQ, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, 32'h301C, 32'h301C);
    check("en0_taken", taken_d, 1'b0);
    tick();
    peek(32'h301C);
    check("gated_pht", pred_taken_f, 1'b0);
    check_stats("gated", 16, 3);
    drive(I_BEQ, 32'd2, 32'd2, 1'b0, 1'b1, 1'b1, 32'h301C, 32'h301C);
    tick();
    peek(32'h301C);
    check("ungated_pht", pred_taken_f, 1'b1);
    check_stats("ungated", 17, 4);

    // Reset coinciding with a resolve: reset wins, table back to 01
    reset = 1'b1;
    drive(I_BEQ, 32'd2, 32'd2, 1'b0, 1'b1, 1'b1, 32'h301C, 32'h3010);
    check("rst_comb_taken", taken_d, 1'b1);
    tick();
    reset = 1'b0;
    peek(32'h301C);
    check("rst_slot7", pred_taken_f, 1'b0);
    peek(32'h3010);
    check("rst_slot4", pred_taken_f, 1'b0);
    check_stats("post_rst", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
